// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: state encoding and datapath widths shared by the memory stage
package mem_stage_pkg;
  localparam int WORD_BITS = 16;
  localparam int REG_BITS = 3;
  typedef enum logic {IDLE, ACCESS} stateT;
endpackage

// File: rtl/data_memory.sv
// data_memory: word-addressed RAM, synchronous write, asynchronous read, contents never reset
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 writeEn,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_BITS-1:0] writeData,
  output logic [WORD_BITS-1:0] readData
);
  logic [WORD_BITS-1:0] mem [2**ADDR_BITS];
  always_ff @(posedge clock)
    if (writeEn) mem[addr] <= writeData;
  assign readData = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: multi-cycle data-memory access with IDLE/ACCESS FSM and MEM/WB output register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic                 MemtoReg_in,
  input  logic                 RegWrite_in,
  input  logic [REG_BITS-1:0]  rd_in,
  input  logic [WORD_BITS-1:0] resultALU_in,
  input  logic [WORD_BITS-1:0] writeData,
  input  logic                 flush,
  output logic                 stall,
  output logic                 valid_out,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [REG_BITS-1:0]  rd_out,
  output logic [WORD_BITS-1:0] dataReadMEM,
  output logic [WORD_BITS-1:0] resultALU
);
  localparam bit MULTI = MEM_LATENCY > 1;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY > 1 ? MEM_LATENCY - 2 : 0);
  stateT state;
  logic [3:0] cnt;
  logic memOp, done, writeEn;
  logic [WORD_BITS-1:0] readData;
  assign memOp = valid_in & (MemRead | MemWrite);
  // done marks the edge at which the instruction leaves the stage with valid_out=1
  always_comb begin
    stall = reset & !flush & (state == ACCESS ? cnt != 4'd0 : memOp & MULTI);
    done = reset & !flush & valid_in & (state == ACCESS ? cnt == 4'd0 : !(memOp & MULTI));
    writeEn = done & memOp & MemWrite;
  end
  data_memory #(.ADDR_BITS(ADDR_BITS)) dmem (
    .clock(clock),
    .writeEn(writeEn),
    .addr(resultALU_in[ADDR_BITS-1:0]),
    .writeData(writeData),
    .readData(readData)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      valid_out <= 1'b0;
      MemtoReg <= 1'b0;
      RegWrite <= 1'b0;
      rd_out <= '0;
      dataReadMEM <= '0;
      resultALU <= '0;
    end else begin
      state <= stall ? ACCESS : IDLE;
      cnt <= !stall ? '0 : state == IDLE ? CNT_LOAD : cnt - 4'd1;
      valid_out <= done;
      MemtoReg <= done & MemtoReg_in;
      RegWrite <= done & RegWrite_in;
      rd_out <= done ? rd_in : '0;
      resultALU <= done ? resultALU_in : '0;
      dataReadMEM <= done & MemRead & !MemWrite ? readData : '0;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage at MEM_LATENCY=3 and MEM_LATENCY=1
module tb_mem_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic valid_in, MemRead, MemWrite, MemtoReg_in, RegWrite_in, flush;
  logic [2:0] rd_in;
  logic [15:0] resultALU_in, writeData;
  logic s3, v3, m3, r3, s1, v1, m1, r1;
  logic [2:0] rd3, rd1;
  logic [15:0] dr3, ra3, dr1, ra1;
  logic sel;
  logic oStall, oValid, oM2R, oRW;
  logic [2:0] oRd;
  logic [15:0] oData, oRes;
  int errors = 0;
  int checks = 0;
  int n;
  mem_stage #(.ADDR_BITS(8), .MEM_LATENCY(3)) d3 (
    .clock(clock), .reset(reset), .valid_in(valid_in), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .rd_in(rd_in), .resultALU_in(resultALU_in),
    .writeData(writeData), .flush(flush), .stall(s3), .valid_out(v3), .MemtoReg(m3), .RegWrite(r3),
    .rd_out(rd3), .dataReadMEM(dr3), .resultALU(ra3)
  );
  mem_stage #(.ADDR_BITS(8), .MEM_LATENCY(1)) d1 (
    .clock(clock), .reset(reset), .valid_in(valid_in), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .rd_in(rd_in), .resultALU_in(resultALU_in),
    .writeData(writeData), .flush(flush), .stall(s1), .valid_out(v1), .MemtoReg(m1), .RegWrite(r1),
    .rd_out(rd1), .dataReadMEM(dr1), .resultALU(ra1)
  );
  always_comb begin
    oStall = sel ? s1 : s3;
    oValid = sel ? v1 : v3;
    oM2R = sel ? m1 : m3;
    oRW = sel ? r1 : r3;
    oRd = sel ? rd1 : rd3;
    oData = sel ? dr1 : dr3;
    oRes = sel ? ra1 : ra3;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic setIn(input logic v, mr, mw, m2r, rw, input logic [2:0] rd, input logic [15:0] alu, wd);
    valid_in = v;
    MemRead = mr;
    MemWrite = mw;
    MemtoReg_in = m2r;
    RegWrite_in = rw;
    rd_in = rd;
    resultALU_in = alu;
    writeData = wd;
  endtask
  task automatic issue(input logic v, mr, mw, m2r, rw, input logic [2:0] rd, input logic [15:0] alu, wd,
                       output int stalls);
    setIn(v, mr, mw, m2r, rw, rd, alu, wd);
    #1;
    stalls = 0;
    while (oStall && stalls < 20) begin
      stalls++;
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    sel = 1'b0;
    flush = 1'b0;
    setIn(1, 0, 1, 0, 0, 0, 16'h0010, 16'h5555);
    #2 reset = 1'b0;
    #1;
    check("rst_valid", 32'(oValid), 0);
    check("rst_rd", 32'(oRd), 0);
    check("rst_res", 32'(oRes), 0);
    check("rst_data", 32'(oData), 0);
    check("rst_stall", 32'(oStall), 0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    #9 reset = 1'b1;
    issue(1, 0, 0, 0, 1, 3'd3, 16'h1234, 16'h0, n);
    check("alu_stalls", 32'(n), 0);
    check("alu_valid", 32'(oValid), 1);
    check("alu_rd", 32'(oRd), 3);
    check("alu_res", 32'(oRes), 32'h1234);
    check("alu_rw", 32'(oRW), 1);
    check("alu_stall", 32'(oStall), 0);
    issue(1, 0, 1, 0, 0, 3'd0, 16'h0010, 16'hBEEF, n);
    check("st_stalls", 32'(n), 2);
    check("st_valid", 32'(oValid), 1);
    check("st_res", 32'(oRes), 32'h0010);
    check("st_data", 32'(oData), 0);
    issue(1, 1, 0, 1, 1, 3'd5, 16'h0010, 16'h0, n);
    check("ld_stalls", 32'(n), 2);
    check("ld_valid", 32'(oValid), 1);
    check("ld_data", 32'(oData), 32'hBEEF);
    check("ld_m2r", 32'(oM2R), 1);
    check("ld_rd", 32'(oRd), 5);
    issue(1, 1, 0, 1, 1, 3'd2, 16'h0110, 16'h0, n);
    check("wrap_data", 32'(oData), 32'hBEEF);
    check("wrap_res", 32'(oRes), 32'h0110);
    setIn(0, 1, 1, 1, 1, 3'd7, 16'hFFFF, 16'hFFFF);
    @(posedge clock);
    #1;
    check("inv_valid", 32'(oValid), 0);
    check("inv_res", 32'(oRes), 0);
    check("inv_rd", 32'(oRd), 0);
    check("inv_rw", 32'(oRW), 0);
    issue(1, 0, 1, 0, 0, 3'd0, 16'h0020, 16'h0001, n);
    check("st20_stalls", 32'(n), 2);
    setIn(1, 0, 1, 0, 0, 3'd0, 16'h0020, 16'h9999);
    #1 check("fl_idle_pre", 32'(oStall), 1);
    flush = 1'b1;
    #1 check("fl_idle_stall", 32'(oStall), 0);
    @(posedge clock);
    #1;
    check("fl_idle_valid", 32'(oValid), 0);
    flush = 1'b0;
    setIn(1, 0, 1, 0, 0, 3'd0, 16'h0020, 16'hDEAD);
    #1 check("fl_c_stall0", 32'(oStall), 1);
    @(posedge clock);
    #1 check("fl_c_stall1", 32'(oStall), 1);
    @(posedge clock);
    #1 check("fl_c_stall2", 32'(oStall), 0);
    flush = 1'b1;
    @(posedge clock);
    #1;
    check("fl_c_valid", 32'(oValid), 0);
    flush = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("fl_c_stall", 32'(oStall), 0);
    issue(1, 1, 0, 1, 1, 3'd1, 16'h0020, 16'h0, n);
    check("fl_mem20", 32'(oData), 32'h0001);
    issue(1, 0, 1, 0, 0, 3'd0, 16'h0030, 16'h1111, n);
    check("st30_valid", 32'(oValid), 1);
    setIn(1, 0, 1, 0, 0, 3'd4, 16'h0030, 16'h7777);
    @(posedge clock);
    #1 check("ra_stall_pre", 32'(oStall), 1);
    #1 reset = 1'b0;
    #1;
    check("ra_stall", 32'(oStall), 0);
    check("ra_valid", 32'(oValid), 0);
    check("ra_res", 32'(oRes), 0);
    check("ra_rd", 32'(oRd), 0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    issue(1, 0, 0, 0, 1, 3'd6, 16'h00AB, 16'h0, n);
    check("ra_alu_stalls", 32'(n), 0);
    check("ra_alu_valid", 32'(oValid), 1);
    check("ra_alu_rd", 32'(oRd), 6);
    check("ra_alu_res", 32'(oRes), 32'h00AB);
    issue(1, 1, 0, 1, 1, 3'd6, 16'h0030, 16'h0, n);
    check("ra_mem30", 32'(oData), 32'h1111);
    sel = 1'b1;
    issue(1, 0, 1, 0, 0, 3'd0, 16'h0044, 16'hCAFE, n);
    check("l1_st_stalls", 32'(n), 0);
    check("l1_st_valid", 32'(oValid), 1);
    check("l1_st_data", 32'(oData), 0);
    issue(1, 1, 0, 1, 1, 3'd2, 16'h0044, 16'h0, n);
    check("l1_ld_stalls", 32'(n), 0);
    check("l1_ld_data", 32'(oData), 32'hCAFE);
    issue(1, 1, 1, 1, 1, 3'd3, 16'h0045, 16'h1357, n);
    check("l1_rw_stalls", 32'(n), 0);
    check("l1_rw_data", 32'(oData), 0);
    issue(1, 1, 0, 1, 1, 3'd3, 16'h0045, 16'h0, n);
    check("l1_rw_ld", 32'(oData), 32'h1357);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
